// File: rtl/gin_bus_multicast.sv
// GIN bus segment: captures one tagged packet and broadcasts it to a row of
// multicast controllers, holding it until every matching controller accepts.
`ifndef XID_BITS
`define XID_BITS 5
`endif

module gin_bus_multicast #(
  parameter int NUM_TARGETS = 8,
  parameter int ID_SIZE     = `XID_BITS,
  parameter int DATA_SIZE   = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ID_SIZE-1:0]             in_tag,
  input  logic [DATA_SIZE-1:0]           in_data,
  input  logic [NUM_TARGETS*ID_SIZE-1:0] target_ids,
  output logic [ID_SIZE-1:0]             bus_tag,
  output logic [DATA_SIZE-1:0]           bus_data,
  output logic [NUM_TARGETS-1:0]         bus_valid,
  input  logic [NUM_TARGETS-1:0]         bus_ready,
  output logic                           busy,
  output logic                           drop_pulse,
  output logic [7:0]                     drop_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_TARGETS-1:0] pending_q, pending_d;
  logic [ID_SIZE-1:0]     bus_tag_q, bus_tag_d;
  logic [DATA_SIZE-1:0]   bus_data_q, bus_data_d;
  logic                   drop_pulse_q, drop_pulse_d;
  logic [7:0]             drop_count_q, drop_count_d;

  logic [NUM_TARGETS-1:0] match;
  logic                   holding;
  logic                   done;
  logic                   fire;

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      match[i] = (target_ids[i*ID_SIZE +: ID_SIZE] == in_tag);
    end
  end

  // done lets a completing HOLD take the next packet in the same cycle
  assign holding  = (state_q == HOLD);
  assign done     = holding && ((pending_q & ~bus_ready) == '0);
  assign in_ready = !holding || done;
  assign fire     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    bus_tag_d    = bus_tag_q;
    bus_data_d   = bus_data_q;
    drop_pulse_d = 1'b0;
    drop_count_d = drop_count_q;

    if (holding) begin
      pending_d = pending_q & ~bus_ready;
      if (done) begin
        state_d = IDLE;
      end
    end

    if (fire) begin
      if (match != '0) begin
        bus_tag_d  = in_tag;
        bus_data_d = in_data;
        pending_d  = match;
        state_d    = HOLD;
      end else begin
        drop_pulse_d = 1'b1;
        if (drop_count_q != 8'hFF) begin
          drop_count_d = drop_count_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pending_q    <= '0;
      bus_tag_q    <= '0;
      bus_data_q   <= '0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      bus_tag_q    <= bus_tag_d;
      bus_data_q   <= bus_data_d;
      drop_pulse_q <= drop_pulse_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign bus_valid  = holding ? pending_q : '0;
  assign bus_tag    = bus_tag_q;
  assign bus_data   = bus_data_q;
  assign busy       = holding;
  assign drop_pulse = drop_pulse_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_gin_bus_multicast.sv
// Directed bench for gin_bus_multicast: unicast, staggered multicast, drops,
// back-to-back capture, hold stability, async reset and drop-count saturation.
module tb_gin_bus_multicast;

  localparam int NT = 8;
  localparam int IW = 5;
  localparam int DW = 32;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     in_tag;
  logic [DW-1:0]     in_data;
  logic [NT*IW-1:0]  target_ids;
  logic [IW-1:0]     bus_tag;
  logic [DW-1:0]     bus_data;
  logic [NT-1:0]     bus_valid;
  logic [NT-1:0]     bus_ready;
  logic              busy;
  logic              drop_pulse;
  logic [7:0]        drop_count;

  logic [IW-1:0]     ids [NT];

  int total = 0;
  int bad   = 0;

  gin_bus_multicast #(
    .NUM_TARGETS(NT),
    .ID_SIZE    (IW),
    .DATA_SIZE  (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_tag    (in_tag),
    .in_data   (in_data),
    .target_ids(target_ids),
    .bus_tag   (bus_tag),
    .bus_data  (bus_data),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .busy      (busy),
    .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < NT; i++) begin
      target_ids[i*IW +: IW] = ids[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic identityIds();
    for (int i = 0; i < NT; i++) begin
      ids[i] = IW'(i);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [IW-1:0] tag,
                               input logic [DW-1:0] data, input logic [NT-1:0] rdy);
    in_valid  = v;
    in_tag    = tag;
    in_data   = data;
    bus_ready = rdy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    identityIds();
    in_valid  = 1'b0;
    in_tag    = '0;
    in_data   = '0;
    bus_ready = '0;
    #13;
    checkOutput("rst_valid", 64'(bus_valid), 64'h0);
    checkOutput("rst_busy", 64'(busy), 64'h0);
    checkOutput("rst_tag", 64'(bus_tag), 64'h0);
    checkOutput("rst_data", 64'(bus_data), 64'h0);
    checkOutput("rst_drop_pulse", 64'(drop_pulse), 64'h0);
    checkOutput("rst_drop_count", 64'(drop_count), 64'h0);
    rst = 1'b0;
    tick();

    // unicast: tag 3 hits target 3 only, accepted immediately
    applyStimulus(1'b1, 5'd3, 32'hA5A5_0001, 8'hFF);
    checkOutput("uni_in_ready_idle", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'hFF);
    checkOutput("uni_valid", 64'(bus_valid), 64'h08);
    checkOutput("uni_tag", 64'(bus_tag), 64'h3);
    checkOutput("uni_data", 64'(bus_data), 64'hA5A5_0001);
    checkOutput("uni_in_ready_done", 64'(in_ready), 64'h1);
    tick();
    checkOutput("uni_valid_after", 64'(bus_valid), 64'h0);
    checkOutput("uni_busy_after", 64'(busy), 64'h0);

    // staggered multicast: targets 0,1,3 share id 2
    ids[0] = 5'd2; ids[1] = 5'd2; ids[2] = 5'd5; ids[3] = 5'd2;
    ids[4] = 5'd4; ids[5] = 5'd6; ids[6] = 5'd7; ids[7] = 5'd9;
    applyStimulus(1'b1, 5'd2, 32'h1234_5678, 8'h00);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h01);
    checkOutput("mc_c1_valid", 64'(bus_valid), 64'h0B);
    checkOutput("mc_c1_in_ready", 64'(in_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'hF5);
    checkOutput("mc_c2_valid", 64'(bus_valid), 64'h0A);
    checkOutput("mc_c2_nonpending_ignored", 64'(in_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h08);
    checkOutput("mc_c3_valid", 64'(bus_valid), 64'h0A);
    checkOutput("mc_c3_in_ready", 64'(in_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h00);
    checkOutput("mc_c4_valid", 64'(bus_valid), 64'h02);
    checkOutput("mc_c4_in_ready", 64'(in_ready), 64'h0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h02);
    checkOutput("mc_c5_valid", 64'(bus_valid), 64'h02);
    checkOutput("mc_c5_in_ready", 64'(in_ready), 64'h1);
    checkOutput("mc_c5_tag", 64'(bus_tag), 64'h2);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h00);
    checkOutput("mc_end_valid", 64'(bus_valid), 64'h0);
    checkOutput("mc_end_busy", 64'(busy), 64'h0);

    // zero match is dropped without touching the bus
    identityIds();
    applyStimulus(1'b1, 5'd31, 32'hDEAD_BEEF, 8'hFF);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'hFF);
    checkOutput("drop_valid", 64'(bus_valid), 64'h0);
    checkOutput("drop_busy", 64'(busy), 64'h0);
    checkOutput("drop_pulse_hi", 64'(drop_pulse), 64'h1);
    checkOutput("drop_count_1", 64'(drop_count), 64'h1);
    checkOutput("drop_in_ready", 64'(in_ready), 64'h1);
    checkOutput("drop_tag_kept", 64'(bus_tag), 64'h2);
    tick();
    checkOutput("drop_pulse_lo", 64'(drop_pulse), 64'h0);
    checkOutput("drop_count_hold", 64'(drop_count), 64'h1);

    // back-to-back with every target ready
    applyStimulus(1'b1, 5'd1, 32'h0000_0011, 8'hFF);
    tick();
    checkOutput("b2b_first_valid", 64'(bus_valid), 64'h02);
    applyStimulus(1'b1, 5'd4, 32'h0000_0044, 8'hFF);
    checkOutput("b2b_in_ready", 64'(in_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'hFF);
    checkOutput("b2b_second_valid", 64'(bus_valid), 64'h10);
    checkOutput("b2b_second_tag", 64'(bus_tag), 64'h4);
    checkOutput("b2b_second_data", 64'(bus_data), 64'h44);
    tick();
    checkOutput("b2b_end_valid", 64'(bus_valid), 64'h0);

    // hold stability while inputs and ids churn
    applyStimulus(1'b1, 5'd6, 32'hCAFE_0006, 8'h00);
    tick();
    checkOutput("stab_valid0", 64'(bus_valid), 64'h40);
    for (int i = 0; i < NT; i++) ids[i] = 5'd2;
    applyStimulus(1'b1, 5'd2, 32'h5555_AAAA, 8'h00);
    checkOutput("stab_in_ready", 64'(in_ready), 64'h0);
    tick();
    checkOutput("stab_tag", 64'(bus_tag), 64'h6);
    checkOutput("stab_data", 64'(bus_data), 64'hCAFE_0006);
    checkOutput("stab_valid1", 64'(bus_valid), 64'h40);
    applyStimulus(1'b0, 5'd2, 32'h5555_AAAA, 8'h40);
    checkOutput("stab_done", 64'(in_ready), 64'h1);
    tick();
    checkOutput("stab_end_busy", 64'(busy), 64'h0);

    // async reset while 0x06 pending
    identityIds();
    ids[1] = 5'd5; ids[2] = 5'd5; ids[5] = 5'd0;
    applyStimulus(1'b1, 5'd5, 32'h0BAD_F00D, 8'h00);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h00);
    checkOutput("rsth_valid_pre", 64'(bus_valid), 64'h06);
    rst = 1'b1;
    #1;
    checkOutput("rsth_valid", 64'(bus_valid), 64'h0);
    checkOutput("rsth_busy", 64'(busy), 64'h0);
    checkOutput("rsth_tag", 64'(bus_tag), 64'h0);
    checkOutput("rsth_data", 64'(bus_data), 64'h0);
    checkOutput("rsth_count", 64'(drop_count), 64'h0);
    checkOutput("rsth_in_ready", 64'(in_ready), 64'h1);
    #2;
    rst = 1'b0;
    tick();
    checkOutput("rsth_stays_idle", 64'(bus_valid), 64'h0);

    // 300 zero-match packets saturate the drop counter at 255
    identityIds();
    applyStimulus(1'b1, 5'd31, 32'h0, 8'hFF);
    for (int k = 0; k < 254; k++) tick();
    checkOutput("sat_count_254", 64'(drop_count), 64'd254);
    for (int k = 0; k < 46; k++) tick();
    checkOutput("sat_count_255", 64'(drop_count), 64'd255);
    checkOutput("sat_pulse", 64'(drop_pulse), 64'h1);
    checkOutput("sat_valid", 64'(bus_valid), 64'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 8'h00);
    tick();
    checkOutput("sat_pulse_lo", 64'(drop_pulse), 64'h0);
    checkOutput("sat_count_hold", 64'(drop_count), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
